// File: rtl/sdram_arbiter.sv
// Two-client arbiter for a byte-wide SDRAM controller port. It also schedules
// periodic auto-refresh and tracks refresh debt so clients never refresh.
`timescale 1ns/1ps

module sdram_arbiter #(
  parameter int FREQ       = 27_000_000,
  parameter int REFRESH_US = 15
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        c0_req,
  input  logic        c0_we,
  input  logic [22:0] c0_addr,
  input  logic [7:0]  c0_din,
  output logic        c0_ack,
  output logic [7:0]  c0_dout,

  input  logic        c1_req,
  input  logic        c1_we,
  input  logic [22:0] c1_addr,
  input  logic [7:0]  c1_din,
  output logic        c1_ack,
  output logic [7:0]  c1_dout,

  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_refresh,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  input  logic        mem_data_ready,
  input  logic        mem_busy,

  output logic        refresh_overrun
);

  localparam int REFRESH_CYCLES = FREQ / 1_000_000 * REFRESH_US;
  localparam int TIMER_W        = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {TGT_REFRESH, TGT_C0, TGT_C1} target_t;

  state_t             state;
  target_t            target;
  logic               op_we;
  logic               last_grant;
  logic [TIMER_W-1:0] timer;
  logic [1:0]         debt;

  logic tick;
  logic refresh_done;
  logic grant_c0;
  logic grant_c1;

  assign tick         = (timer == TIMER_LAST);
  assign refresh_done = (state == WAIT) && (target == TGT_REFRESH) && !mem_busy;

  // Refresh debt outranks both clients; on a tie the client that did not win
  // the previous tie goes first.
  assign grant_c0 = (debt == 2'd0) && c0_req && (!c1_req || last_grant);
  assign grant_c1 = (debt == 2'd0) && c1_req && !grant_c0;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // A tick and a completed refresh in the same cycle cancel out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      debt            <= 2'd0;
      refresh_overrun <= 1'b0;
    end else begin
      case ({tick, refresh_done})
        2'b10: begin
          if (debt == 2'd3) begin
            refresh_overrun <= 1'b1;
          end else begin
            debt <= debt + 2'd1;
          end
        end
        2'b01:   debt <= debt - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      target      <= TGT_REFRESH;
      op_we       <= 1'b0;
      last_grant  <= 1'b1;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_refresh <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      c0_ack      <= 1'b0;
      c1_ack      <= 1'b0;
      c0_dout     <= '0;
      c1_dout     <= '0;
    end else begin
      // Pulses and acks are one cycle wide; they are set only on entry to
      // ISSUE or DONE respectively.
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_refresh <= 1'b0;
      c0_ack      <= 1'b0;
      c1_ack      <= 1'b0;

      case (state)
        IDLE: begin
          if (!mem_busy) begin
            if (debt != 2'd0) begin
              target      <= TGT_REFRESH;
              op_we       <= 1'b0;
              mem_refresh <= 1'b1;
              state       <= ISSUE;
            end else if (grant_c0) begin
              target   <= TGT_C0;
              op_we    <= c0_we;
              mem_addr <= c0_addr;
              mem_din  <= c0_din;
              mem_wr   <= c0_we;
              mem_rd   <= !c0_we;
              state    <= ISSUE;
              if (c1_req) last_grant <= 1'b0;
            end else if (grant_c1) begin
              target   <= TGT_C1;
              op_we    <= c1_we;
              mem_addr <= c1_addr;
              mem_din  <= c1_din;
              mem_wr   <= c1_we;
              mem_rd   <= !c1_we;
              state    <= ISSUE;
              if (c0_req) last_grant <= 1'b1;
            end
          end
        end

        ISSUE: state <= WAIT;

        WAIT: begin
          if (target == TGT_REFRESH) begin
            if (!mem_busy) state <= IDLE;
          end else if (op_we) begin
            if (!mem_busy) begin
              c0_ack <= (target == TGT_C0);
              c1_ack <= (target == TGT_C1);
              state  <= DONE;
            end
          end else if (mem_data_ready) begin
            if (target == TGT_C0) begin
              c0_dout <= mem_dout;
            end else begin
              c1_dout <= mem_dout;
            end
            c0_ack <= (target == TGT_C0);
            c1_ack <= (target == TGT_C1);
            state  <= DONE;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a small SDRAM controller model with a
// fixed busy time, an event log sampled on the falling edge, one task per scenario.
`timescale 1ns/1ps

module tb_sdram_arbiter;

  localparam int N        = 405;
  localparam int BUSY_LAT = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [22:0] c0_addr, c1_addr;
  logic [7:0]  c0_din, c1_din;
  logic        c0_ack, c1_ack;
  logic [7:0]  c0_dout, c1_dout;
  logic        mem_rd, mem_wr, mem_refresh;
  logic [22:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_data_ready, mem_busy;
  logic        refresh_overrun;

  int errors = 0;
  int checks = 0;

  sdram_arbiter #(.FREQ(27_000_000), .REFRESH_US(15)) dut (
    .clk(clk), .resetn(resetn),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_din(c0_din),
    .c0_ack(c0_ack), .c0_dout(c0_dout),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_din(c1_din),
    .c1_ack(c1_ack), .c1_dout(c1_dout),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_data_ready(mem_data_ready), .mem_busy(mem_busy),
    .refresh_overrun(refresh_overrun)
  );

  always #5 clk = ~clk;

  // Controller model: busy for BUSY_LAT cycles after any pulse; a read
  // returns data with a one-cycle data_ready as busy drops.
  logic        model_busy;
  logic        force_busy = 1'b0;
  int          busy_cnt;
  logic        rd_pend;
  logic [22:0] rd_addr;
  logic [7:0]  mem_model [logic [22:0]];

  assign mem_busy = model_busy | force_busy;

  function automatic logic [7:0] read_model(input logic [22:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_busy     <= 1'b0;
      busy_cnt       <= 0;
      rd_pend        <= 1'b0;
      rd_addr        <= '0;
      mem_data_ready <= 1'b0;
      mem_dout       <= '0;
    end else begin
      mem_data_ready <= 1'b0;
      if (mem_rd || mem_wr || mem_refresh) begin
        model_busy <= 1'b1;
        busy_cnt   <= BUSY_LAT;
        rd_pend    <= mem_rd;
        rd_addr    <= mem_addr;
        if (mem_wr) mem_model[mem_addr] = mem_din;
      end else if (model_busy) begin
        if (busy_cnt == 1) begin
          model_busy <= 1'b0;
          if (rd_pend) begin
            mem_data_ready <= 1'b1;
            mem_dout       <= read_model(rd_addr);
          end
        end else begin
          busy_cnt <= busy_cnt - 1;
        end
      end
    end
  end

  // Event log, sampled mid-cycle.
  typedef enum int {EV_RD, EV_WR, EV_REF, EV_ACK0, EV_ACK1} ev_code_t;
  typedef struct {
    ev_code_t    code;
    logic [22:0] addr;
    logic [7:0]  data;
    logic [7:0]  d1;
    int          cyc;
  } ev_t;

  ev_t ev_log[$];
  int  cyc         = 0;
  int  multi_pulse = 0;
  int  dual_ack    = 0;

  always @(negedge clk) begin
    ev_t e;
    cyc++;
    e.addr = mem_addr;
    e.d1   = c1_dout;
    e.cyc  = cyc;
    if (mem_rd)      begin e.code = EV_RD;   e.data = mem_din; ev_log.push_back(e); end
    if (mem_wr)      begin e.code = EV_WR;   e.data = mem_din; ev_log.push_back(e); end
    if (mem_refresh) begin e.code = EV_REF;  e.data = mem_din; ev_log.push_back(e); end
    if (c0_ack)      begin e.code = EV_ACK0; e.data = c0_dout; ev_log.push_back(e); end
    if (c1_ack)      begin e.code = EV_ACK1; e.data = c1_dout; ev_log.push_back(e); end
    if (int'(mem_rd) + int'(mem_wr) + int'(mem_refresh) > 1) multi_pulse++;
    if (c0_ack && c1_ack) dual_ack++;
  end

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_din = '0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_din = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  // One client transaction, started at a falling edge; returns dout at ack.
  task automatic do_op(input bit c, input bit we, input logic [22:0] a,
                       input logic [7:0] d, output logic [7:0] q);
    bit got = 1'b0;
    q = 8'h00;
    if (!c) begin c0_we = we; c0_addr = a; c0_din = d; c0_req = 1'b1; end
    else    begin c1_we = we; c1_addr = a; c1_din = d; c1_req = 1'b1; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (!c && c0_ack) begin got = 1'b1; q = c0_dout; end
      if (c && c1_ack)  begin got = 1'b1; q = c1_dout; end
    end
    if (!c) c0_req = 1'b0; else c1_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL op_timeout client=%0d addr=%h: no ack within 200 cycles, required ack", c, a);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({c0_ack, c1_ack, mem_rd, mem_wr, mem_refresh, mem_addr, mem_din,
         c0_dout, c1_dout, refresh_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero (addr=%h din=%h d0=%h d1=%h), required all 0",
               mem_addr, mem_din, c0_dout, c1_dout);
    end
    checks++;
    if (dut.debt !== 2'd0 || dut.timer !== '0) begin
      errors++;
      $display("FAIL reset_state: debt=%0d timer=%0d, required 0/0", dut.debt, dut.timer);
    end
    apply_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr, mem_refresh, c0_ack, c1_ack} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset: pulses/acks=%b, required 00000",
               {mem_rd, mem_wr, mem_refresh, c0_ack, c1_ack});
    end
  endtask

  task automatic test_refresh_idle();
    int start;
    ev_t refs[$];
    apply_reset();
    start = ev_log.size();
    repeat (3 * N + 10) @(negedge clk);
    for (int i = start; i < ev_log.size(); i++)
      if (ev_log[i].code == EV_REF) refs.push_back(ev_log[i]);
    checks++;
    if (refs.size() != 3) begin
      errors++;
      $display("FAIL refresh_count: got %0d refresh pulses, required 3", refs.size());
    end
    for (int i = 1; i < refs.size(); i++) begin
      checks++;
      if (refs[i].cyc - refs[i-1].cyc != N) begin
        errors++;
        $display("FAIL refresh_spacing: gap %0d, required %0d", refs[i].cyc - refs[i-1].cyc, N);
      end
    end
    checks++;
    if (dut.debt !== 2'd0 || refresh_overrun !== 1'b0) begin
      errors++;
      $display("FAIL refresh_idle_end: debt=%0d overrun=%b, required 0/0", dut.debt, refresh_overrun);
    end
  endtask

  task automatic test_write_read();
    int start;
    logic [7:0] q;
    ev_t seq[$];
    start = ev_log.size();
    do_op(1'b0, 1'b1, 23'h000001, 8'h3E, q);
    do_op(1'b0, 1'b0, 23'h000001, 8'h00, q);
    @(negedge clk);
    for (int i = start; i < ev_log.size(); i++)
      if (ev_log[i].code != EV_REF) seq.push_back(ev_log[i]);
    checks++;
    if (seq.size() != 4) begin
      errors++;
      $display("FAIL wr_rd_events: got %0d events, required 4 (wr,ack0,rd,ack0)", seq.size());
    end else begin
      checks++;
      if (seq[0].code != EV_WR || seq[1].code != EV_ACK0 ||
          seq[2].code != EV_RD || seq[3].code != EV_ACK0) begin
        errors++;
        $display("FAIL wr_rd_order: codes %0d %0d %0d %0d, required %0d %0d %0d %0d",
                 seq[0].code, seq[1].code, seq[2].code, seq[3].code, EV_WR, EV_ACK0, EV_RD, EV_ACK0);
      end
      checks++;
      if (seq[0].addr !== 23'h000001 || seq[0].data !== 8'h3E || seq[2].addr !== 23'h000001) begin
        errors++;
        $display("FAIL wr_rd_addr: wr addr=%h din=%h rd addr=%h, required 000001/3e/000001",
                 seq[0].addr, seq[0].data, seq[2].addr);
      end
    end
    checks++;
    if (q !== 8'h3E || c0_dout !== 8'h3E) begin
      errors++;
      $display("FAIL readback: q=%h c0_dout=%h, required 3e", q, c0_dout);
    end
  endtask

  task automatic test_alternate();
    logic [22:0] a0 [4] = '{23'h000100, 23'h000101, 23'h000102, 23'h000103};
    logic [7:0]  e0 [4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};
    logic [22:0] a1 [4] = '{23'h0002C0, 23'h0002C1, 23'h0002C2, 23'h0002C3};
    logic [7:0]  e1 [4] = '{8'h9A, 8'h9B, 8'h98, 8'h99};
    int start;
    int k0;
    ev_t acks[$];
    apply_reset();
    start = ev_log.size();
    fork
      begin
        logic [7:0] q0;
        for (int k = 0; k < 4; k++) begin
          do_op(1'b0, 1'b0, a0[k], 8'h00, q0);
          checks++;
          if (q0 !== e0[k]) begin
            errors++;
            $display("FAIL alt_c0_data[%0d]: got %h, required %h", k, q0, e0[k]);
          end
        end
      end
      begin
        logic [7:0] q1;
        for (int k = 0; k < 4; k++) begin
          do_op(1'b1, 1'b0, a1[k], 8'h00, q1);
          checks++;
          if (q1 !== e1[k]) begin
            errors++;
            $display("FAIL alt_c1_data[%0d]: got %h, required %h", k, q1, e1[k]);
          end
        end
      end
    join
    @(negedge clk);
    for (int i = start; i < ev_log.size(); i++)
      if (ev_log[i].code == EV_ACK0 || ev_log[i].code == EV_ACK1) acks.push_back(ev_log[i]);
    checks++;
    if (acks.size() != 8) begin
      errors++;
      $display("FAIL alt_ack_count: got %0d acks, required 8", acks.size());
    end else begin
      k0 = 0;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (acks[i].code != ((i % 2 == 0) ? EV_ACK0 : EV_ACK1)) begin
          errors++;
          $display("FAIL alt_order[%0d]: got client %0d, required client %0d",
                   i, (acks[i].code == EV_ACK1) ? 1 : 0, i % 2);
        end
        if (acks[i].code == EV_ACK0) begin
          checks++;
          if (acks[i].d1 !== ((k0 == 0) ? 8'h00 : e1[k0-1])) begin
            errors++;
            $display("FAIL alt_c1_hold[%0d]: c1_dout=%h, required %h",
                     k0, acks[i].d1, (k0 == 0) ? 8'h00 : e1[k0-1]);
          end
          k0++;
        end
      end
    end
  endtask

  task automatic test_refresh_during_read();
    int start;
    ev_code_t want [5] = '{EV_RD, EV_ACK0, EV_REF, EV_RD, EV_ACK1};
    apply_reset();
    repeat (N - 4) @(negedge clk);
    start = ev_log.size();
    fork
      begin
        logic [7:0] q0;
        do_op(1'b0, 1'b0, 23'h000050, 8'h00, q0);
        checks++;
        if (q0 !== 8'h0A) begin
          errors++;
          $display("FAIL rdr_c0_data: got %h, required 0a", q0);
        end
      end
      begin
        logic [7:0] q1;
        do_op(1'b1, 1'b0, 23'h000060, 8'h00, q1);
        checks++;
        if (q1 !== 8'h3A) begin
          errors++;
          $display("FAIL rdr_c1_data: got %h, required 3a", q1);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (ev_log.size() - start != 5) begin
      errors++;
      $display("FAIL rdr_events: got %0d events, required 5 (rd0,ack0,ref,rd1,ack1)", ev_log.size() - start);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (ev_log[start+i].code != want[i]) begin
          errors++;
          $display("FAIL rdr_order[%0d]: got event %0d, required %0d", i, ev_log[start+i].code, want[i]);
        end
      end
    end
  endtask

  task automatic test_busy_overrun();
    int start;
    int nref;
    force_busy = 1'b1;
    apply_reset();
    start = ev_log.size();
    repeat (4 * N + 5) @(negedge clk);
    checks++;
    if (dut.debt !== 2'd3 || refresh_overrun !== 1'b1 || ev_log.size() != start) begin
      errors++;
      $display("FAIL overrun_set: debt=%0d overrun=%b events=%0d, required 3/1/0",
               dut.debt, refresh_overrun, ev_log.size() - start);
    end
    force_busy = 1'b0;
    start = ev_log.size();
    repeat (60) @(negedge clk);
    nref = 0;
    for (int i = start; i < ev_log.size(); i++)
      if (ev_log[i].code == EV_REF) nref++;
    checks++;
    if (nref != 3 || dut.debt !== 2'd0) begin
      errors++;
      $display("FAIL overrun_drain: refreshes=%0d debt=%0d, required 3/0", nref, dut.debt);
    end
    checks++;
    if (refresh_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: overrun=%b, required 1", refresh_overrun);
    end
    apply_reset();
    checks++;
    if (refresh_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_reset: overrun=%b, required 0", refresh_overrun);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] q;
    bit seen = 1'b0;
    int start;
    int nack;
    do_op(1'b0, 1'b0, 23'h0000AB, 8'h00, q);
    checks++;
    if (q !== 8'hF1) begin
      errors++;
      $display("FAIL pre_reset_read: got %h, required f1", q);
    end
    c0_we = 1'b0; c0_addr = 23'h0000CD; c0_req = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_rd) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_read_issue: no mem_rd within 20 cycles, required a pulse");
    end
    @(negedge clk);
    start = ev_log.size();
    resetn = 1'b0;
    c0_req = 1'b0;
    #1;
    checks++;
    if ({c0_ack, c1_ack, mem_rd, mem_wr, mem_refresh, mem_addr, mem_din,
         c0_dout, c1_dout, refresh_overrun} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: addr=%h din=%h d0=%h d1=%h, required all 0",
               mem_addr, mem_din, c0_dout, c1_dout);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    nack = 0;
    for (int i = start; i < ev_log.size(); i++)
      if (ev_log[i].code == EV_ACK0 || ev_log[i].code == EV_ACK1) nack++;
    checks++;
    if (nack != 0) begin
      errors++;
      $display("FAIL aborted_ack: got %0d acks after reset, required 0", nack);
    end
    start = ev_log.size();
    fork
      begin
        logic [7:0] q0;
        do_op(1'b0, 1'b0, 23'h000011, 8'h00, q0);
        checks++;
        if (q0 !== 8'h4B) begin
          errors++;
          $display("FAIL post_reset_c0: got %h, required 4b", q0);
        end
      end
      begin
        logic [7:0] q1;
        do_op(1'b1, 1'b0, 23'h000022, 8'h00, q1);
        checks++;
        if (q1 !== 8'h78) begin
          errors++;
          $display("FAIL post_reset_c1: got %h, required 78", q1);
        end
      end
    join
    checks++;
    if (ev_log.size() == start || ev_log[start].code != EV_RD || ev_log[start].addr !== 23'h000011) begin
      errors++;
      $display("FAIL post_reset_tie: first grant is not client 0 read of 000011");
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (multi_pulse != 0) begin
      errors++;
      $display("FAIL multi_pulse: %0d cycles with >1 controller pulse, required 0", multi_pulse);
    end
    checks++;
    if (dual_ack != 0) begin
      errors++;
      $display("FAIL dual_ack: %0d cycles with both acks, required 0", dual_ack);
    end
  endtask

  initial begin
    resetn = 1'b0;
    c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_din = '0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_din = '0;
    test_reset();
    test_refresh_idle();
    test_write_read();
    test_alternate();
    test_refresh_during_read();
    test_busy_overrun();
    test_reset_mid_read();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the byte-wide sdram controller port (rd/wr/refresh pulses, addr, din, dout, data_ready, busy) between two independent requesters.
- Generates periodic auto-refresh itself, so clients never issue refresh.
- Sits between the application logic (test FSMs, CPU/PPU-style clients) and the sdram controller instance, in the clk domain.

Parameters:
- FREQ, 27_000_000, clk frequency in Hz.
- REFRESH_US, 15, refresh interval in microseconds.
- REFRESH_CYCLES, FREQ/1_000_000*REFRESH_US (405), derived clk cycles per refresh tick. Localparam, not overridable.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- c0_req  in  1  client 0 request level; hold with fields stable until c0_ack.
- c0_we  in  1  client 0: 1 = write, 0 = read.
- c0_addr  in  23  client 0 byte address.
- c0_din  in  8  client 0 write data.
- c0_ack  out  1  client 0 one-cycle completion pulse.
- c0_dout  out  8  client 0 read data, valid from c0_ack, held until its next read ack.
- c1_req, c1_we, c1_addr, c1_din, c1_ack, c1_dout: same as client 0, for client 1.
- mem_rd  out  1  read pulse to sdram controller.
- mem_wr  out  1  write pulse.
- mem_refresh  out  1  refresh pulse.
- mem_addr  out  23  address to controller.
- mem_din  out  8  write data to controller.
- mem_dout  in  8  read data from controller.
- mem_data_ready  in  1  read data valid pulse.
- mem_busy  in  1  controller busy.
- refresh_overrun  out  1  sticky error flag: refresh debt overflowed.

Behaviour:
- Reset (resetn=0, async): state=IDLE; all outputs 0; c0_dout/c1_dout=0; timer=0; debt=0; last_grant=1 (client 0 wins first tie).
- Reset mid-transaction aborts immediately; no ack is generated.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1 and wraps; each wrap is a tick.
  - Debt is a 2-bit counter: +1 per tick, -1 per refresh issued.
  - Tick and issue in the same cycle leave debt unchanged.
  - Tick with debt=3 keeps debt=3 and sets refresh_overrun (cleared only by reset).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE (arbitration, evaluated only when mem_busy=0):
  - Priority 1: debt>0 → target=refresh.
  - Priority 2: one client requesting → grant it.
  - Priority 3: both requesting → grant the client not equal to last_grant, then update last_grant.
  - Latch the granted client's we/addr/din into mem_addr/mem_din; go to ISSUE.
  - Nothing pending → stay in IDLE.
- ISSUE (exactly 1 cycle): assert exactly one of mem_rd/mem_wr/mem_refresh; go to WAIT. The pulses are never asserted in any other state.
- WAIT:
  - Read: done on mem_data_ready. Capture mem_dout into that client's dout register on that edge.
  - Write/refresh: done on the first WAIT cycle with mem_busy=0. WAIT is entered one cycle after the pulse, when the controller already shows busy.
  - On done: a client op goes to DONE; refresh decrements debt and goes to IDLE.
- DONE (1 cycle): pulse the granted client's ack (dout already valid); go to IDLE.
  - The client samples ack and may drop req or present a new request in the next cycle; IDLE sees the updated req.
- Addresses and data pass through unmodified; no width conversion. mem_addr/mem_din hold their values until the next grant.
- Client dropping req mid-transaction is illegal. The arbiter still completes the operation and pulses ack.
- Throughput: a write to an idle controller acks IDLE→ISSUE→WAIT(n)→DONE, minimum 4 cycles after grant plus the controller's busy time.
- At most one ack per cycle; c0_ack and c1_ack are never simultaneous.

Test Plan:
- Client 0 writes 0x3E @ 0x000001, then reads 0x000001 → exactly one mem_wr pulse then one mem_rd pulse, each with mem_addr=0x000001; c0_ack twice; c0_dout=0x3E after the second ack; c1_ack never asserted.
- c0_req and c1_req asserted in the same cycle, held, for 4 reads each to distinct addresses → grants alternate 0,1,0,1,…; each ack carries the correct data; c1_dout is unchanged by client-0 reads.
- No client activity for 3*REFRESH_CYCLES+10 cycles → exactly 3 mem_refresh pulses, spaced REFRESH_CYCLES apart; debt returns to 0; refresh_overrun stays 0.
- Refresh tick occurs during a client read → the read completes and acks first; mem_refresh is pulsed in the next arbitration, ahead of a waiting c1_req.
- mem_busy held high for 4*REFRESH_CYCLES → debt saturates at 3 and refresh_overrun=1; after mem_busy is released, 3 refreshes are issued and the flag stays 1 until reset.
- resetn pulled low in WAIT of a read, then released → no ack; all outputs 0; next c0_req is served normally, and client 0 wins a simultaneous tie.
